// File: rtl/da2_wave_gen.sv
// Dual-channel 12-bit waveform source for DA2_Top: per-channel phase accumulators
// sampled on a fixed-rate tick and presented with a one-cycle update strobe.
module da2_wave_gen #(
    parameter int SAMPLE_DIV = 1000,
    parameter int PHASE_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_clr,
    input  logic [1:0]         wave_sel0,
    input  logic [1:0]         wave_sel1,
    input  logic [PHASE_W-1:0] step0,
    input  logic [PHASE_W-1:0] step1,
    output logic [11:0]        value0,
    output logic [11:0]        value1,
    output logic               update
);

    localparam logic [15:0] CNT_LAST = 16'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        WAVE_DC  = 2'b00,
        WAVE_SAW = 2'b01,
        WAVE_TRI = 2'b10,
        WAVE_SQR = 2'b11
    } wave_t;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        tick;
    logic        update_q;

    logic [1:0][1:0]         sel_a;
    logic [1:0][PHASE_W-1:0] step_a;

    assign sel_a  = {wave_sel1, wave_sel0};
    assign step_a = {step1, step0};

    // Sample shape from the phase; low phase bits below the 12-bit window are dropped.
    function automatic logic [11:0] wave_fn(input logic [PHASE_W-1:0] p, input logic [1:0] sel);
        logic [11:0] res;
        logic        msb;
        logic [11:0] low;
        msb = p[PHASE_W-1];
        low = p[PHASE_W-2 -: 12];
        case (wave_t'(sel))
            WAVE_DC:  res = 12'h800;
            WAVE_SAW: res = p[PHASE_W-1 -: 12];
            WAVE_TRI: res = msb ? ~low : low;
            WAVE_SQR: res = msb ? 12'hFFF : 12'h000;
            default:  res = 12'h800;
        endcase
        return res;
    endfunction

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!en || tick) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 16'd0;
            update_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            update_q <= tick;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [PHASE_W-1:0] ph_q;
            logic [PHASE_W-1:0] ph_d;
            logic [PHASE_W-1:0] ph_cur;
            logic [11:0]        val_q;
            logic [11:0]        val_d;

            // A clear coincident with a tick replaces the old phase for this sample.
            assign ph_cur = phase_clr ? '0 : ph_q;

            always_comb begin
                ph_d  = ph_q;
                val_d = val_q;
                if (tick) begin
                    val_d = wave_fn(ph_cur, sel_a[gi]);
                    ph_d  = ph_cur + step_a[gi];
                end else if (phase_clr) begin
                    ph_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ph_q  <= '0;
                    val_q <= 12'h000;
                end else begin
                    ph_q  <= ph_d;
                    val_q <= val_d;
                end
            end
        end
    endgenerate

    assign value0 = g_ch[0].val_q;
    assign value1 = g_ch[1].val_q;
    assign update = update_q;

endmodule

// File: tb/tb_da2_wave_gen.sv
// Directed scoreboard bench for da2_wave_gen: expected sample pairs are queued
// as stimulus is applied and checked whenever update fires.
module tb_da2_wave_gen;

    localparam int SAMPLE_DIV = 100;
    localparam int PHASE_W    = 16;

    logic               clk;
    logic               rst;
    logic               en;
    logic               phase_clr;
    logic [1:0]         wave_sel0;
    logic [1:0]         wave_sel1;
    logic [PHASE_W-1:0] step0;
    logic [PHASE_W-1:0] step1;
    logic [11:0]        value0;
    logic [11:0]        value1;
    logic               update;

    int          tests = 0;
    int          fails = 0;
    int          popped = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          gap_valid = 0;
    logic [23:0] sb_q[$];

    logic [11:0] tri_t [9] = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'hFFF,
                               12'hBFF, 12'h7FF, 12'h3FF, 12'h000};

    da2_wave_gen #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .PHASE_W   (PHASE_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .phase_clr(phase_clr),
        .wave_sel0(wave_sel0),
        .wave_sel1(wave_sel1),
        .step0    (step0),
        .step1    (step1),
        .value0   (value0),
        .value1   (value1),
        .update   (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [11:0] v0, input logic [11:0] v1);
        sb_q.push_back({v0, v1});
    endtask

    // Monitor: every update pops one expected pair and checks spacing.
    always @(posedge clk) begin
        logic [23:0] e;
        #1;
        if (update === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("queue_nonempty_at_update", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("value0", value0, e[23:12]);
                chk("value1", value1, e[11:0]);
                $display("[TB] sample %0d: value0=%03h value1=%03h (exp %03h/%03h)",
                         popped, value0, value1, e[23:12], e[11:0]);
            end
            if (gap_valid) chk("update_gap", cyc - last_cyc, SAMPLE_DIV);
            last_cyc  = cyc;
            gap_valid = 1;
            popped++;
        end
    end

    task automatic wait_updates(input int n);
        int target;
        int lim;
        target = popped + n;
        lim    = 0;
        while (popped < target && lim < n * SAMPLE_DIV + 200) begin
            @(negedge clk);
            lim++;
        end
        if (popped < target) chk("update_timeout", popped, target);
    endtask

    // Called on the edge-preceding negedge; counts rising edges until update shows.
    task automatic count_to_update(input string tag);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #2;
        end while (update !== 1'b1 && k < 1000);
        chk(tag, k, SAMPLE_DIV);
    endtask

    initial begin
        int bad;
        rst       = 1'b0;
        en        = 1'b0;
        phase_clr = 1'b0;
        wave_sel0 = 2'b01;
        wave_sel1 = 2'b00;
        step0     = 16'h1000;
        step1     = 16'h0000;

        // Reset state
        #1;
        chk("rst_value0", value0, 12'h000);
        chk("rst_value1", value1, 12'h000);
        chk("rst_update", update, 1'b0);
        repeat (3) @(negedge clk);

        // Sawtooth on ch0, DC on ch1; first tick SAMPLE_DIV edges after release
        for (int i = 0; i < 17; i++) push(12'((i % 16) << 8), 12'h800);
        rst = 1'b1;
        en  = 1'b1;
        count_to_update("first_tick_latency");
        wait_updates(16);

        // DC on ch0, triangle on ch1
        wave_sel0 = 2'b00;
        wave_sel1 = 2'b10;
        step1     = 16'h2000;
        for (int i = 0; i < 9; i++) push(12'h800, tri_t[i]);
        wait_updates(9);

        // Mid-period clear, then square on ch0 with a mid-period step change
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        wave_sel0 = 2'b11;
        step0     = 16'h4000;
        push(12'h000, tri_t[0]);
        push(12'h000, tri_t[1]);
        wait_updates(2);
        step0 = 16'h8000;
        push(12'hFFF, tri_t[2]);
        push(12'h000, tri_t[3]);
        push(12'hFFF, tri_t[4]);
        wait_updates(3);

        // Enable low for 37 cycles mid-period: no update, values hold
        repeat (30) @(posedge clk);
        @(negedge clk);
        en        = 1'b0;
        gap_valid = 0;
        wave_sel0 = 2'b01;
        step0     = 16'h1000;
        bad       = 0;
        repeat (37) begin
            @(posedge clk);
            #2;
            if (update !== 1'b0 || value0 !== 12'hFFF || value1 !== 12'hFFF) bad++;
        end
        chk("en_low_hold", bad, 0);
        push(12'h000, 12'hBFF);
        @(negedge clk);
        en = 1'b1;
        count_to_update("reenable_latency");

        // Clear coincident with a tick: sample uses phase 0, phase becomes step
        push(12'h000, 12'h000);
        push(12'h100, 12'h400);
        repeat (99) @(posedge clk);
        @(negedge clk);
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        wait_updates(1);

        // Asynchronous reset mid-count
        repeat (40) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_value0", value0, 12'h000);
        chk("midrst_value1", value1, 12'h000);
        chk("midrst_update", update, 1'b0);
        gap_valid = 0;
        repeat (3) @(negedge clk);
        push(12'h000, 12'h000);
        push(12'h100, 12'h400);
        rst = 1'b1;
        count_to_update("post_reset_latency");
        wait_updates(1);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
